// File: rtl/lab3_serial_pattern_tx_if.sv
// Handshake and serial-output bundle for the serial pattern transmitter.
// master: the word producer (bench or board top); slave: the transmitter.
interface lab3_serial_pattern_tx_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [3:0]       in_len;
    logic             abort;
    logic             x;
    logic             x_valid;
    logic             x_last;
    logic             busy;

    modport master (
        output in_valid, in_data, in_len, abort,
        input  in_ready, x, x_valid, x_last, busy
    );

    modport slave (
        input  in_valid, in_data, in_len, abort,
        output in_ready, x, x_valid, x_last, busy
    );
endinterface

// File: rtl/lab3_serial_pattern_tx.sv
// Serial pattern transmitter: accepts a parallel word plus bit count and
// emits the significant bits MSB-first on x, one per clock, followed by a
// single idle gap cycle. x/x_valid/x_last are registered outputs.
module lab3_serial_pattern_tx #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input logic                      clock,
    input logic                      reset,
    lab3_serial_pattern_tx_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       count_q, count_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             x_last_q, x_last_d;
    logic [3:0]       len_eff;
    logic [WIDTH-1:0] load_word;

    // Effective length (0 or oversize means full width) and MSB-aligned load word.
    always_comb begin
        if (bus.in_len == 4'd0 || bus.in_len > 4'(WIDTH)) begin
            len_eff = 4'(WIDTH);
        end else begin
            len_eff = bus.in_len;
        end
        load_word = bus.in_data << (4'(WIDTH) - len_eff);
    end

    // Next-state and next-output decode; outputs default to the idle level.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shreg_d   = shreg_q;
        x_d       = IDLE_LEVEL;
        x_valid_d = 1'b0;
        x_last_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // abort blocks acceptance even though in_ready is high
                if (!bus.abort && bus.in_valid) begin
                    state_d   = SHIFT;
                    count_d   = len_eff;
                    shreg_d   = load_word;
                    x_d       = load_word[WIDTH-1];
                    x_valid_d = 1'b1;
                    x_last_d  = (len_eff == 4'd1);
                end
            end
            SHIFT: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    count_d = 4'd0;
                end else if (count_q == 4'd1) begin
                    state_d = GAP;
                    count_d = 4'd0;
                end else begin
                    shreg_d   = shreg_q << 1;
                    count_d   = count_q - 4'd1;
                    x_d       = shreg_q[WIDTH-2];
                    x_valid_d = 1'b1;
                    x_last_d  = (count_q == 4'd2);
                end
            end
            GAP: begin
                state_d = IDLE;
                count_d = 4'd0;
            end
            default: begin
                state_d = IDLE;
                count_d = 4'd0;
            end
        endcase
    end

    // Control state and registered serial outputs, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= 4'd0;
            x_q       <= IDLE_LEVEL;
            x_valid_q <= 1'b0;
            x_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            x_last_q  <= x_last_d;
        end
    end

    // Shift register holds data only; its contents are ignored outside SHIFT.
    always_ff @(posedge clock) begin
        shreg_q <= shreg_d;
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.x        = x_q;
    assign bus.x_valid  = x_valid_q;
    assign bus.x_last   = x_last_q;
endmodule

// File: tb/tb_lab3_serial_pattern_tx.sv
// Bench for lab3_serial_pattern_tx: directed scenarios plus random frames,
// checked against a bit-sequence model derived from the word and length.
module tb_lab3_serial_pattern_tx;
    localparam int   W    = 8;
    localparam logic IDLE = 1'b0;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    lab3_serial_pattern_tx_if #(.WIDTH(W)) bus ();

    lab3_serial_pattern_tx #(.WIDTH(W), .IDLE_LEVEL(IDLE)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int eff_len(input logic [3:0] len);
        if (len == 0 || int'(len) > W) return W;
        return int'(len);
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_x"},        32'(bus.x),        32'(IDLE));
        chk({tag, "_x_valid"},  32'(bus.x_valid),  0);
        chk({tag, "_x_last"},   32'(bus.x_last),   0);
        chk({tag, "_busy"},     32'(bus.busy),     0);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("ready_wait", 32'(bus.in_ready), 1);
    endtask

    // Checks a whole frame starting in the cycle after the accept edge.
    task automatic run_frame(input logic [W-1:0] data, input logic [3:0] len, input bit scramble);
        int L = eff_len(len);
        for (int k = 0; k < L; k++) begin
            if (scramble) begin
                bus.in_data = W'($urandom);
                bus.in_len  = 4'($urandom);
            end
            chk("bit_x_valid",  32'(bus.x_valid),  1);
            chk("bit_x",        32'(bus.x),        32'(data[L-1-k]));
            chk("bit_x_last",   32'(bus.x_last),   32'(k == L - 1));
            chk("bit_busy",     32'(bus.busy),     1);
            chk("bit_in_ready", 32'(bus.in_ready), 0);
            tick();
        end
        chk("gap_x_valid",  32'(bus.x_valid),  0);
        chk("gap_x",        32'(bus.x),        32'(IDLE));
        chk("gap_x_last",   32'(bus.x_last),   0);
        chk("gap_busy",     32'(bus.busy),     1);
        chk("gap_in_ready", 32'(bus.in_ready), 0);
        tick();
        chk("post_in_ready", 32'(bus.in_ready), 1);
    endtask

    task automatic accept(input logic [W-1:0] data, input logic [3:0] len);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_len   = len;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] data, input logic [3:0] len, input bit scramble);
        accept(data, len);
        run_frame(data, len, scramble);
    endtask

    initial begin
        logic [W-1:0] word;
        logic [W-1:0] cur;
        logic         prev_v;
        bit           acc;
        int           rises[$];

        // reset held with a word offered
        bus.abort    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        bus.in_len   = 4'd8;
        reset        = 1'b1;
        tick();
        tick();
        check_idle("reset");
        reset = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        run_frame(8'hA5, 4'd8, 1'b0);

        // short frames and the zero-length rule
        send_frame(8'hFD, 4'd3, 1'b0);
        send_frame(8'h0F, 4'd0, 1'b0);
        send_frame(8'h5A, 4'd1, 1'b0);
        send_frame(8'h96, 4'd12, 1'b1);

        // back-to-back frames with in_valid held high
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_len   = 4'd8;
        word   = 8'h00;
        cur    = 8'h00;
        prev_v = 1'b0;
        for (int i = 0; i < 45; i++) begin
            if (bus.x_valid && !prev_v) rises.push_back(cyc);
            if (bus.x_valid) chk("b2b_x", 32'(bus.x), 32'(cur[0]));
            prev_v = bus.x_valid;
            acc = bus.in_ready;
            if (acc) begin
                word = (word == 8'hFF) ? 8'h00 : 8'hFF;
                bus.in_data = word;
            end
            tick();
            if (acc) cur = word;
        end
        bus.in_valid = 1'b0;
        chk("b2b_rise_count", 32'(rises.size() >= 4), 1);
        for (int i = 1; i < rises.size(); i++) begin
            chk("b2b_period", 32'(rises[i] - rises[i-1]), 10);
        end
        wait_ready();
        tick();

        // abort on the 4th bit
        accept(8'hFF, 4'd8);
        for (int k = 0; k < 3; k++) begin
            chk("abort_pre_x", 32'(bus.x), 1);
            tick();
        end
        chk("abort_bit4_valid", 32'(bus.x_valid), 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_idle("abort");
        for (int i = 0; i < 10; i++) begin
            chk("abort_no_last", 32'(bus.x_last | bus.x_valid), 0);
            tick();
        end

        // abort with in_valid in IDLE: word must not be taken
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        bus.in_len   = 4'd8;
        tick();
        chk("idle_abort_busy",  32'(bus.busy),    0);
        chk("idle_abort_valid", 32'(bus.x_valid), 0);
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check_idle("idle_abort_after");

        // asynchronous reset during the 5th bit
        accept(8'hB6, 4'd8);
        for (int k = 0; k < 4; k++) begin
            chk("rst_pre_x", 32'(bus.x), 32'(8'hB6 >> (7 - k) & 8'h01));
            tick();
        end
        #3;
        reset = 1'b1;
        #1;
        check_idle("async_rst");
        #2;
        reset = 1'b0;
        tick();
        check_idle("post_rst");
        send_frame(8'h3C, 4'd8, 1'b0);

        // random frames, inputs scrambled mid-frame
        for (int i = 0; i < 20; i++) begin
            word = W'($urandom);
            send_frame(word, 4'($urandom_range(0, 15)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lab3_serial_pattern_tx.md
# lab3_serial_pattern_tx

Serial pattern transmitter: the driving end of the single-bit serial input consumed by the lab's Mealy sequence-detector blocks. It accepts a parallel word and a bit count over a valid/ready handshake, then emits the significant bits MSB-first, one bit per clock, on `x` with a `x_valid` qualifier. A one-cycle idle gap separates frames. This block lets benches and board top-levels feed detectors from parallel stimulus (switches, ROM) instead of hand-clocked inputs.

## Interface
- `WIDTH`, default 8: maximum frame length in bits; legal range 2..15.
- `IDLE_LEVEL`, default 1'b0: level driven on `x` whenever `x_valid`=0.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  word offered.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `in_data`  in  WIDTH  word; bits [len-1:0] are significant.
- `in_len`  in  4  bits to send; 0 or values >WIDTH mean WIDTH.
- `abort`  in  1  synchronous frame cancel.
- `x`  out  1  serial bit, registered.
- `x_valid`  out  1  `x` carries a frame bit, registered.
- `x_last`  out  1  current bit is the frame's final bit, registered.
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE: `in_ready`=1. On `in_valid`&`in_ready` at an edge: latch effective length L (1..WIDTH), load shift register with `in_data << (WIDTH-L)` (MSB-aligned, upper bits discarded), count=L; go to SHIFT.
- SHIFT: on each edge, shift left by one and decrement count. `x` = shift-register MSB. `x_last`=1 when count==1. When count==1 at an edge, go to GAP.
- GAP: single cycle; `x`=IDLE_LEVEL, `x_valid`=0; then IDLE.
- `abort` high at an edge in SHIFT or GAP: go to IDLE; count cleared; `x`=IDLE_LEVEL, `x_valid`=0, `x_last`=0 from that edge. In IDLE, `abort` has priority over acceptance: no word is taken that cycle.
- `in_data`/`in_len` are sampled only at the accept edge. Later changes have no effect.
- Unused `in_data` bits above L never appear on `x`.

## Timing
- Reset (asynchronous, immediate): state=IDLE, `x`=IDLE_LEVEL, `x_valid`=0, `x_last`=0, `busy`=0, `in_ready`=1.
- Accept at edge T: first bit on `x` with `x_valid`=1 during cycle T+1. Bit k (0=MSB of L bits) is valid during T+1+k.
- Final bit at T+L, with `x_last`=1. GAP at T+L+1. IDLE and `in_ready`=1 at T+L+2. Earliest next accept is the edge ending T+L+2, so back-to-back frames repeat every L+2 cycles.
- `in_ready` and `busy` are decoded from state. `x`, `x_valid` and `x_last` are flop outputs, and each changes only on clock edges or reset.
- Reset asserted mid-frame: outputs return to reset values immediately. The remaining bits are dropped, and no `x_last` is emitted.
- L=1: a single cycle with `x_valid`=`x_last`=1, then GAP.

## Test plan
- Reset check: assert `reset` with `in_valid`=1 -> `x`=0, `x_valid`=0, `x_last`=0, `busy`=0, `in_ready`=1. Release -> word accepted on the next edge.
- `in_data`=8'hA5, `in_len`=8 -> over 8 cycles `x`=1,0,1,0,0,1,0,1 with `x_valid`=1. `x_last` only on the 8th bit. One gap cycle follows, then `in_ready`=1.
- `in_data`=8'hFD, `in_len`=3 -> `x`=1,0,1 only, and the upper 5 bits are never emitted. `in_len`=0 with 8'h0F -> 0,0,0,0,1,1,1,1.
- `in_valid` held high with alternating words 8'hFF/8'h00, `in_len`=8 -> `x_valid` rising edges exactly 10 cycles apart. `in_data` changed mid-frame -> no effect on `x`.
- Send 8'hFF, `in_len`=8, and pulse `abort` on the 4th bit -> `x_valid`=0 from the next edge, no `x_last`. With `abort`=`in_valid`=1 in IDLE -> not accepted.
- Assert `reset` asynchronously between edges on bit 5 of a frame -> outputs go to reset values without waiting for a clock edge. The next frame after release starts clean from its MSB.
